acondicionador_botones: RTL

- Input-side counterpart of the clock's mode controller: turns the four raw active-low push-buttons (incrementar, decrementar, cambiar, establecer) into clean, debounced, single-cycle command pulses.
- Adds hold-to-repeat on incrementar/decrementar so time/alarm values can be swept.
- Sits between the board pins and the mode-control logic, on the same clock.

---
 rtl/acondicionador_botones.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/acondicionador_botones.sv
// acondicionador_botones: turns the four raw active-low push-buttons into
// debounced levels and single-cycle command pulses. Increment and decrement
// also auto-repeat while held, and they lock each other out when both are
// pressed.
module acondicionador_botones #(
  parameter int DEB_CYCLES    = 1000000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       incrementar_n,
  input  logic       decrementar_n,
  input  logic       cambiar_n,
  input  logic       establecer_n,
  output logic       pulso_inc,
  output logic       pulso_dec,
  output logic       pulso_cambiar,
  output logic       pulso_establecer,
  output logic [3:0] estado
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int CW = (HW > RW) ? HW : RW;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, BLOQ} rep_state_t;

  // Channel order: bit0 inc, bit1 dec, bit2 cambiar, bit3 establecer.
  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    stable;
  logic [3:0]    stable_nxt;
  logic [3:0]    press;
  logic [DW-1:0] cnt [4];
  logic [1:0]    rep_pulse;

  assign raw    = {establecer_n, cambiar_n, decrementar_n, incrementar_n};
  assign estado = ~stable;

  // Next debounced level and press event (1->0 acceptance) per channel.
  always_comb begin
    stable_nxt = stable;
    press      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if ((sync2[i] != stable[i]) && (cnt[i] == DEB_LAST)) begin
        stable_nxt[i] = sync2[i];
        press[i]      = ~sync2[i];
      end
    end
  end

  // Two-flop synchronisers, debounce counters and debounced levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      stable <= stable_nxt;
      for (int unsigned i = 0; i < 4; i++) begin
        if ((sync2[i] == stable[i]) || (cnt[i] == DEB_LAST)) cnt[i] <= '0;
        else                                                 cnt[i] <= cnt[i] + DW'(1);
      end
    end
  end

  // Single press pulses for cambiar/establecer, aligned with the estado change.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulso_cambiar    <= 1'b0;
      pulso_establecer <= 1'b0;
    end else begin
      pulso_cambiar    <= press[2];
      pulso_establecer <= press[3];
    end
  end

  for (genvar g = 0; g < 2; g++) begin : gen_rep
    rep_state_t    st;
    logic [CW-1:0] rc;
    logic          pulse;
    logic          own_rel;
    logic          other_pr;

    // Both use the level accepted at this edge, so a release or the other
    // button's press takes effect on the same edge as the debounce update.
    assign own_rel  = stable_nxt[g];
    assign other_pr = ~stable_nxt[1-g];

    // Hold-to-repeat FSM with inc/dec mutual lockout.
    always_ff @(posedge clk) begin
      if (reset) begin
        st    <= IDLE;
        rc    <= '0;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        case (st)
          IDLE: begin
            if (press[g]) begin
              rc <= '0;
              if (other_pr) begin
                st <= BLOQ;
              end else begin
                st    <= HOLD;
                pulse <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (own_rel) begin
              st <= IDLE;
            end else if (other_pr) begin
              st <= BLOQ;
            end else if (rc == HOLD_LAST) begin
              st    <= REPEAT;
              rc    <= '0;
              pulse <= 1'b1;
            end else begin
              rc <= rc + CW'(1);
            end
          end
          REPEAT: begin
            if (own_rel) begin
              st <= IDLE;
            end else if (other_pr) begin
              st <= BLOQ;
            end else if (rc == REP_LAST) begin
              rc    <= '0;
              pulse <= 1'b1;
            end else begin
              rc <= rc + CW'(1);
            end
          end
          BLOQ: begin
            if (own_rel) st <= IDLE;
          end
          default: st <= IDLE;
        endcase
      end
    end

    assign rep_pulse[g] = pulse;
  end

  assign pulso_inc = rep_pulse[0];
  assign pulso_dec = rep_pulse[1];

endmodule
